// File: rtl/encode8_3_arb.sv
// Pending-request register with an 8-to-3 encoder that offers one index at a time
// to a valid/ready consumer, using round-robin (RR=1) or lowest-index (RR=0) selection.
module encode8_3_arb #(
  parameter int RR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       req_load,
  input  logic       clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic [7:0] pending,
  output logic [3:0] cnt,
  output logic       err,
  output logic       dbg_state
);

  // Handshake: a transfer happens on a rising edge where out_valid && out_ready;
  // out_valid/out_idx never change while out_valid is high and out_ready is low.
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t     state, state_next;
  logic [2:0] ptr, ptr_next;
  logic [2:0] idx_next;
  logic [2:0] sel, base, probe;
  logic       sel_found;
  logic [7:0] kept, pending_next;
  logic       hs;
  logic       err_next;

  assign out_valid = (state == OFFER);
  assign dbg_state = state;

  // A clr edge cancels any handshake so nothing is retired or pointer-advanced.
  assign hs   = out_valid && out_ready && !clr;
  assign kept = pending & ~(8'({7'b0, hs}) << out_idx);

  always_comb begin
    pending_next = kept | (req_load ? req : 8'h00);
    if (clr) pending_next = 8'h00;
  end

  // Duplicate only if the bit survives this edge; a bit retired now and re-requested is fresh.
  assign err_next = !clr && req_load && (|(req & kept));

  always_comb begin
    ptr_next = ptr;
    if (clr)     ptr_next = 3'd0;
    else if (hs) ptr_next = out_idx + 3'd1;
  end

  // Search from the updated pointer so the just-served index becomes lowest priority.
  always_comb begin
    sel       = 3'd0;
    sel_found = 1'b0;
    probe     = 3'd0;
    base      = (RR != 0) ? ptr_next : 3'd0;
    for (int i = 0; i < 8; i++) begin
      probe = base + 3'(i);
      if (!sel_found && pending_next[probe]) begin
        sel       = probe;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    case (state)
      IDLE: begin
        if (pending_next != 8'h00) begin
          state_next = OFFER;
          idx_next   = sel;
        end
      end
      OFFER: begin
        if (clr) begin
          state_next = IDLE;
        end else if (hs) begin
          if (pending_next != 8'h00) idx_next = sel;
          else state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_idx <= 3'd0;
      pending <= 8'h00;
      ptr     <= 3'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      out_idx <= idx_next;
      pending <= pending_next;
      ptr     <= ptr_next;
      err     <= err_next;
    end
  end

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, pending[i]};
  end

endmodule

// File: tb/tb_encode8_3_arb.sv
// Bench for encode8_3_arb: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a set-based model, plus directed scenarios.
module tb_encode8_3_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       req_load;
  logic       clr;
  logic       out_ready;

  logic [1:0]      ov;
  logic [1:0][2:0] oi;
  logic [1:0][7:0] pend;
  logic [1:0][3:0] cn;
  logic [1:0]      er;
  logic [1:0]      dbg;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  encode8_3_arb #(.RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .req_load(req_load), .clr(clr),
    .out_ready(out_ready), .out_valid(ov[0]), .out_idx(oi[0]), .pending(pend[0]),
    .cnt(cn[0]), .err(er[0]), .dbg_state(dbg[0])
  );

  encode8_3_arb #(.RR(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .req_load(req_load), .clr(clr),
    .out_ready(out_ready), .out_valid(ov[1]), .out_idx(oi[1]), .pending(pend[1]),
    .cnt(cn[1]), .err(er[1]), .dbg_state(dbg[1])
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: index 0 is round-robin, index 1 is fixed-priority
  bit [7:0] mp[2];
  bit       mv[2];
  int       mi[2];
  int       mptr[2];
  bit       merr[2];

  function automatic int pick(input bit [7:0] p, input int start);
    for (int i = 0; i < 8; i++)
      if (p[(start + i) % 8]) return (start + i) % 8;
    return 0;
  endfunction

  function automatic int ones(input bit [7:0] p);
    int n = 0;
    for (int i = 0; i < 8; i++) n += p[i];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mp[k] = 0; mv[k] = 0; mi[k] = 0; mptr[k] = 0; merr[k] = 0;
      end else begin
        bit       served;
        bit [7:0] left;
        served = mv[k] && out_ready && !clr;
        left   = mp[k];
        if (served) left[mi[k]] = 1'b0;
        merr[k] = 0;
        if (clr) begin
          mp[k] = 0; mv[k] = 0; mptr[k] = 0;
        end else begin
          if (req_load)
            for (int b = 0; b < 8; b++) if (req[b] && left[b]) merr[k] = 1;
          mp[k] = left | (req_load ? req : 8'h00);
          if (served) mptr[k] = (mi[k] + 1) % 8;
          if (!mv[k] || served) begin
            if (mp[k] == 0) mv[k] = 0;
            else begin
              mv[k] = 1;
              mi[k] = pick(mp[k], (k == 0) ? mptr[k] : 0);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "rr_valid" : "fx_valid", ov[k], mv[k]);
        if (mv[k]) chk(k == 0 ? "rr_idx" : "fx_idx", oi[k], mi[k]);
        chk(k == 0 ? "rr_pending" : "fx_pending", pend[k], mp[k]);
        chk(k == 0 ? "rr_cnt" : "fx_cnt", cn[k], ones(mp[k]));
        chk(k == 0 ? "rr_err" : "fx_err", er[k], merr[k]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit l, input logic [7:0] r, input bit rdy, input bit c);
    req_load  = l;
    req       = r;
    out_ready = rdy;
    clr       = c;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", ov[k], 0);
      chk("reset_pending", pend[k], 0);
      chk("reset_cnt", cn[k], 0);
      chk("reset_err", er[k], 0);
    end
    rst_n    = 1'b1;
    check_en = 1'b1;

    // full load drained at one index per cycle
    set_in(1, 8'hFF, 1, 0);
    tick();
    set_in(0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) begin
      chk("ff_rr_idx", oi[0], i);
      chk("ff_fx_idx", oi[1], i);
      chk("ff_cnt", cn[0], 8 - i);
      tick();
    end
    chk("ff_done_valid", ov[0], 0);

    // pointer 6 after serving index 5
    set_in(1, 8'h20, 1, 0); tick();
    chk("p5_idx", oi[0], 5);
    set_in(0, 8'h00, 1, 0); tick();
    set_in(1, 8'h21, 0, 0); tick();
    chk("x21_rr_first", oi[0], 0);
    chk("x21_fx_first", oi[1], 0);
    set_in(0, 8'h00, 1, 0); tick();
    chk("x21_rr_second", oi[0], 5);
    chk("x21_fx_second", oi[1], 5);
    tick();
    chk("x21_idle", ov[0], 0);
    set_in(1, 8'h30, 0, 0); tick();
    chk("x30_rr_first", oi[0], 4);
    chk("model_x30_first", mi[0], 4);
    set_in(0, 8'h00, 1, 0); tick();
    chk("x30_rr_second", oi[0], 5);
    tick();
    set_in(1, 8'h41, 0, 0); tick();
    chk("x41_rr_from_ptr6", oi[0], 6);
    chk("x41_fx_lowest", oi[1], 0);
    chk("model_x41_rr", mi[0], 6);
    set_in(0, 8'h00, 1, 0); repeat (4) tick();

    // stall holds the offer while a lower index arrives
    set_in(0, 8'h00, 0, 1); tick();
    set_in(1, 8'h10, 0, 0); tick();
    chk("stall_idx_a", oi[0], 4); chk("stall_cnt_a", cn[0], 1);
    set_in(1, 8'h01, 0, 0); tick();
    chk("stall_idx_b", oi[0], 4); chk("stall_cnt_b", cn[0], 2);
    set_in(0, 8'h00, 0, 0); tick();
    chk("stall_idx_c", oi[0], 4); chk("stall_cnt_c", cn[0], 2);
    set_in(0, 8'h00, 1, 0); tick();
    chk("stall_after_hs", oi[0], 0); chk("stall_cnt_d", cn[0], 1);
    tick();
    chk("stall_drained", ov[0], 0); chk("stall_cnt_e", cn[0], 0);

    // duplicate request vs fresh re-request
    set_in(1, 8'h08, 0, 0); tick();
    chk("dup_idx", oi[0], 3); chk("dup_err_pre", er[0], 0);
    set_in(1, 8'h08, 0, 0); tick();
    chk("dup_err", er[0], 1); chk("dup_cnt", cn[0], 1);
    set_in(0, 8'h00, 0, 0); tick();
    chk("dup_err_one_cycle", er[0], 0);
    set_in(1, 8'h08, 1, 0); tick();
    chk("fresh_err", er[0], 0); chk("fresh_valid", ov[0], 1);
    chk("fresh_idx", oi[0], 3); chk("fresh_cnt", cn[0], 1);
    set_in(0, 8'h00, 1, 0); tick();
    chk("fresh_drained", ov[0], 0);

    // clr overrides a same-edge load
    set_in(1, 8'h0F, 0, 0); tick();
    set_in(1, 8'hFF, 0, 1); tick();
    chk("clr_valid", ov[0], 0); chk("clr_pending", pend[0], 0); chk("clr_cnt", cn[0], 0);

    // asynchronous reset mid-offer
    set_in(1, 8'h81, 0, 0); tick();
    chk("pre_rst_pending", pend[0], 8'h81);
    set_in(0, 8'h00, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", ov[k], 0);
      chk("arst_pending", pend[k], 0);
      chk("arst_cnt", cn[k], 0);
      chk("arst_err", er[k], 0);
    end
    tick();
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 9) < 4, 8'($urandom_range(0, 255)),
             $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      tick();
    end
    set_in(0, 8'h00, 1, 0);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
